// File: rtl/mem_responder_pkg.sv
// Shared types and default parameter values for the mem_responder slice.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int          DEF_WIDTH     = 32;
  localparam int          DEF_ADDR      = 10;
  localparam int          DEF_LATENCY   = 2;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h00010000;

endpackage

// File: rtl/mem_array.sv
// Word-addressed single-port storage with per-byte write enables and a
// read-before-write output register. Contents are never reset.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR  = DEF_ADDR
) (
  input  logic               clk,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [ADDR-1:0]    idx_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic [WIDTH/8-1:0] wstrb_i,
  output logic [WIDTH-1:0]   rdata_o
);

  localparam int SW = WIDTH / 8;

  logic [WIDTH-1:0] mem_q [2**ADDR];
  logic [WIDTH-1:0] rdata_q;

  // Output register captures the word as it was before this edge's write.
  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[idx_i];
      for (int b = 0; b < SW; b++) begin
        if (we_i && wstrb_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Data-port memory responder: ack one cycle after a request, ready LATENCY
// wait states later. Define MEM_RESPONDER_ALIGN_CHECK_EN to fault misaligned addresses.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          WIDTH     = DEF_WIDTH,
  parameter int          ADDR      = DEF_ADDR,
  parameter int          LATENCY   = DEF_LATENCY,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [31:0]        addr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  output logic [WIDTH-1:0]   rdata,
  output logic               ready,
  output logic               ack,
  output logic               err
);

  localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [WIDTH/8-1:0] wstrb_q, wstrb_d;
  op_e                op_q, op_d;

  logic [31:0]        offset_s;
  logic [31:0]        word_s;
  logic               fault_s;
  logic               ram_en_s;
  logic               ram_we_s;
  logic [WIDTH-1:0]   ram_rdata_s;

  // Decode is done on the latched address so the request inputs can drop after ack.
  assign offset_s = addr_q - BASE_ADDR;
  assign word_s   = offset_s >> 2;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign fault_s  = (addr_q < BASE_ADDR) || (word_s >= (32'd1 << ADDR)) || (addr_q[1:0] != 2'b00);
`else
  assign fault_s  = (addr_q < BASE_ADDR) || (word_s >= (32'd1 << ADDR));
`endif
  assign ram_en_s = (state_q == RESP) && !fault_s;
  assign ram_we_s = ram_en_s && (op_q == OP_WRITE);

  mem_array #(
    .WIDTH (WIDTH),
    .ADDR  (ADDR)
  ) u_mem_array (
    .clk     (clk),
    .en_i    (ram_en_s),
    .we_i    (ram_we_s),
    .idx_i   (word_s[ADDR-1:0]),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .rdata_o (ram_rdata_s)
  );

  // Next-state and output logic for the IDLE/WAIT/RESP handshake.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    rvalid_d = rvalid_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    op_d     = op_q;
    case (state_q)
      IDLE: begin
        if (read || write) begin
          addr_d  = addr;
          wdata_d = wdata;
          wstrb_d = wstrb;
          op_d    = write ? OP_WRITE : OP_READ;
          ack_d   = 1'b1;
          cnt_d   = CW'(LATENCY);
          state_d = (LATENCY > 0) ? WAIT : RESP;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        ready_d  = 1'b1;
        err_d    = fault_s;
        rvalid_d = !fault_s;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-request registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      addr_q   <= 32'h0000_0000;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      op_q     <= OP_READ;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      op_q     <= op_d;
    end
  end

  // A faulted access zeroes rdata until the next good access completes.
  assign rdata = rvalid_q ? ram_rdata_s : '0;
  assign ready = ready_q;
  assign ack   = ack_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a LATENCY=2 instance for the main
// scenarios and a LATENCY=0 instance for held-request back-to-back behaviour.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int LAT = 2;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        read, write;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready, ack, err;

  logic        read0, write0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  wstrb0;
  logic [31:0] rdata0;
  logic        ready0, ack0, err0;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_responder #(.WIDTH(32), .ADDR(10), .LATENCY(LAT), .BASE_ADDR(32'h00010000)) u_dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .ack(ack), .err(err)
  );

  mem_responder #(.WIDTH(32), .ADDR(10), .LATENCY(0), .BASE_ADDR(32'h00010000)) u_dut0 (
    .clk(clk), .reset(reset), .read(read0), .write(write0), .addr(addr0), .wdata(wdata0),
    .wstrb(wstrb0), .rdata(rdata0), .ready(ready0), .ack(ack0), .err(err0)
  );

  task automatic xact(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic chk, input logic [31:0] exp_rd,
                      input logic exp_err, input string name);
    exp_t e;
    int   n;
    sb_q.push_back('{rd: exp_rd, err: exp_err, chk_rd: chk});
    @(negedge clk);
    read = rd; write = wr; addr = a; wdata = wd; wstrb = ws;
    @(negedge clk);
    n_tests++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL %s ack: got %b want 1", name, ack); end
    read = 1'b0; write = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 12) begin @(negedge clk); n++; end
    n_tests++;
    if (n !== LAT + 1) begin n_fail++; $display("FAIL %s ready_delay: got %0d want %0d", name, n, LAT + 1); end
    e = sb_q.pop_front();
    n_tests++;
    if (err !== e.err) begin n_fail++; $display("FAIL %s err: got %b want %b", name, err, e.err); end
    if (e.chk_rd) begin
      n_tests++;
      if (rdata !== e.rd) begin n_fail++; $display("FAIL %s rdata: got %h want %h", name, rdata, e.rd); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    read = 1'b0; write = 1'b0; addr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
    read0 = 1'b0; write0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; wstrb0 = 4'h0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ack, ready, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {ack, ready, err}); end
    n_tests++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_after_reset();
    xact(1'b0, 1'b1, 32'h00010000, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0, "preload_w0");
    xact(1'b1, 1'b0, 32'h00010000, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, "read_w0");
    @(negedge clk);
    n_tests++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_pulse: got %b want 0", ready); end
  endtask

  task automatic test_byte_strobe();
    xact(1'b0, 1'b1, 32'h00010004, 32'hAAAAAAAA, 4'hF, 1'b0, 32'h0, 1'b0, "fill_w1");
    xact(1'b0, 1'b1, 32'h00010004, 32'h11223344, 4'b0101, 1'b0, 32'h0, 1'b0, "strobe_w1");
    xact(1'b1, 1'b0, 32'h00010004, 32'h0, 4'h0, 1'b1, 32'hAA22AA44, 1'b0, "read_w1");
  endtask

  task automatic test_rmw();
    xact(1'b0, 1'b1, 32'h00010008, 32'h00000005, 4'hF, 1'b0, 32'h0, 1'b0, "fill_w2");
    xact(1'b1, 1'b1, 32'h00010008, 32'h00000009, 4'hF, 1'b1, 32'h00000005, 1'b0, "rmw_w2");
    xact(1'b1, 1'b0, 32'h00010008, 32'h0, 4'h0, 1'b1, 32'h00000009, 1'b0, "read_w2");
    repeat (3) @(negedge clk);
    n_tests++;
    if (rdata !== 32'h00000009) begin n_fail++; $display("FAIL rdata_hold: got %h want 00000009", rdata); end
  endtask

  task automatic test_zero_strobe();
    xact(1'b0, 1'b1, 32'h00010008, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0, 1'b0, "zero_strobe");
    xact(1'b1, 1'b0, 32'h00010008, 32'h0, 4'h0, 1'b1, 32'h00000009, 1'b0, "read_after_zs");
  endtask

  task automatic test_out_of_range();
    xact(1'b0, 1'b1, 32'h00010FFC, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 1'b0, "write_last");
    xact(1'b1, 1'b0, 32'h0000FFFC, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, "oor_low_read");
    xact(1'b0, 1'b1, 32'h00011000, 32'h12345678, 4'hF, 1'b1, 32'h0, 1'b1, "oor_high_write");
    xact(1'b0, 1'b1, 32'h0000FFFC, 32'h87654321, 4'hF, 1'b1, 32'h0, 1'b1, "oor_low_write");
    xact(1'b1, 1'b0, 32'h00010000, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, "w0_intact");
    xact(1'b1, 1'b0, 32'h00010FFC, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D, 1'b0, "last_intact");
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    write = 1'b1; addr = 32'h00010004; wdata = 32'h00000000; wstrb = 4'hF;
    @(negedge clk);
    n_tests++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL midrst_ack: got %b want 1", ack); end
    write = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({ack, ready, err} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags: got %b want 000", {ack, ready, err}); end
    n_tests++;
    if (u_dut.state_q !== IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d want %0d", u_dut.state_q, IDLE); end
    @(negedge clk);
    reset = 1'b0;
    xact(1'b1, 1'b0, 32'h00010004, 32'h0, 4'h0, 1'b1, 32'hAA22AA44, 1'b0, "midrst_old_word");
  endtask

  task automatic test_align();
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    xact(1'b1, 1'b0, 32'h00010002, 32'h0, 4'h0, 1'b1, 32'h00000000, 1'b1, "misaligned_read");
`else
    xact(1'b1, 1'b0, 32'h00010002, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, "misaligned_read");
`endif
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic ack_exp, rdy_exp;
    @(negedge clk);
    write0 = 1'b1; addr0 = 32'h00010000; wdata0 = 32'h5A5A5A5A; wstrb0 = 4'hF;
    @(negedge clk);
    n_tests++;
    if (ack0 !== 1'b1) begin n_fail++; $display("FAIL b2b_write_ack: got %b want 1", ack0); end
    write0 = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ready0 !== 1'b1) begin n_fail++; $display("FAIL b2b_write_ready: got %b want 1", ready0); end
    @(negedge clk);
    read0 = 1'b1; addr0 = 32'h00010000;
    sb_q.push_back('{rd: 32'h5A5A5A5A, err: 1'b0, chk_rd: 1'b1});
    sb_q.push_back('{rd: 32'h5A5A5A5A, err: 1'b0, chk_rd: 1'b1});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      ack_exp = (c == 1 || c == 3);
      rdy_exp = (c == 2 || c == 4);
      n_tests++;
      if ({ack0, ready0} !== {ack_exp, rdy_exp}) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d ack/ready: got %b%b want %b%b", c, ack0, ready0, ack_exp, rdy_exp);
      end
      if (ready0 === 1'b1 && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_tests++;
        if ({err0, rdata0} !== {e.err, e.rd}) begin
          n_fail++;
          $display("FAIL b2b_data: got err=%b rdata=%h want err=%b rdata=%h", err0, rdata0, e.err, e.rd);
        end
      end
    end
    read0 = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (sb_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_byte_strobe();
    test_rmw();
    test_zero_strobe();
    test_out_of_range();
    test_reset_mid_op();
    test_align();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's data-port request protocol: read/write requests with byte strobes, answered by a one-cycle ack and a later one-cycle ready.
- Backed by an internal word-addressed RAM with a programmable number of wait states.
- Sits on the data port of riscv32 as the slave end of the data_read_valid/data_write_valid/data_ack/data_ready handshake.
- A second instance can serve the instruction port with write tied low.

Parameters:
- WIDTH, 32, data word width in bits; byte strobe width is WIDTH/8.
- ADDR, 10, log2 of RAM depth in words.
- LATENCY, 2, wait-state cycles between ack and ready (0 allowed).
- BASE_ADDR, 32'h00010000, byte address of word 0.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- read  input  1  read request
- write  input  1  write request
- addr  input  32  byte address
- wdata  input  WIDTH  write data
- wstrb  input  WIDTH/8  per-byte write enable
- rdata  output  WIDTH  read data, valid when ready=1
- ready  output  1  one-cycle pulse: access complete
- ack  output  1  one-cycle pulse: request accepted
- err  output  1  one-cycle pulse with ready: access faulted

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, ack=0, ready=0, err=0, rdata=0, wait counter=0.
  - RAM contents are not reset.
- Reset mid-operation aborts the access. An uncommitted write is never applied.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Requests (read|write) are sampled only in IDLE.
  - On sampling at edge N: latch addr, wdata, wstrb and op; ack=1 for the cycle after edge N; counter=LATENCY.
  - Next state is WAIT if LATENCY>0, else RESP.
- WAIT: counter decrements each cycle; at counter==1, next state is RESP.
- RESP:
  - The access executes at this edge. The write commits bytes where wstrb[i]=1.
  - ready=1 (and rdata, err) during the following cycle, then return to IDLE.
  - ack at cycle N+1 and ready at cycle N+2+LATENCY.
- Back-to-back requests:
  - The earliest next acceptance is the edge ending the ready cycle.
  - The initiator must drop read/write after seeing ack. A request still high on IDLE re-entry is treated as a new request.
- Simultaneous read and write: a write is performed; rdata returns the pre-write word (read-modify-write view).
- Write with wstrb=0: no bytes change; ack/ready still produced.
- Address decode: word index = (addr-BASE_ADDR)>>2.
- Out-of-range address (below BASE_ADDR or index ≥ 2^ADDR): write dropped, rdata=0, err=1 with ready.
- rdata holds its value between ready pulses.
- ack and ready are registered outputs with no combinational path from inputs.

Optional Feature:
- Macro MEM_RESPONDER_ALIGN_CHECK_EN.
- When defined: addr[1:0]≠0 is a fault. The access is not performed, rdata=0, and err=1 with ready. Latency is unchanged.
- When undefined: addr[1:0] is ignored (the access targets the containing word) and err reflects only out-of-range.

Decomposition:
- Package mem_responder_pkg:
  - state enum (IDLE, WAIT, RESP).
  - op typedef (OP_READ, OP_WRITE).
  - default parameter constants.
- Sub-module mem_array: synchronous single-port RAM with per-byte write enables and read-before-write output. It holds only the storage array; control FSM, counter and decode stay in mem_responder.

Test Plan:
- Read after reset, LATENCY=2: preload word 0 = 32'hDEADBEEF. Pulse read with addr=32'h00010000 at edge 0 → ack in cycle 1, ready in cycle 4, rdata=32'hDEADBEEF, err=0.
- Byte-strobe write: write addr=32'h00010004, wdata=32'h11223344, wstrb=4'b0101 over word 32'hAAAAAAAA → subsequent read returns 32'hAA22AA44.
- Simultaneous read+write: word=32'h00000005, write 32'h00000009 with wstrb=4'hF → ready with rdata=32'h00000005; next read returns 32'h00000009.
- Out-of-range: read addr=32'h0000FFFC, then write addr=BASE_ADDR+(4<<ADDR) → both ack, ready with err=1 and rdata=0; no RAM word changes.
- Reset mid-op: assert reset one cycle after the ack of a write → ack/ready/err go low immediately, state returns to IDLE, and a read of the target word returns its old value.
- LATENCY=0 with request held high: ack and ready in consecutive cycles. A request still high at IDLE re-entry is accepted again (second ack two cycles after the first).
- With MEM_RESPONDER_ALIGN_CHECK_EN: read addr=32'h00010002 → err=1, rdata=0. Without the macro, the same read returns word 0.
